// File: rtl/rca_pkg.sv
// Shared types and constants for the nibble-serial ripple-carry adder.
package rca_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 4;

  // Controller states: wait for operands, add one slice per cycle, hold result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of compute cycles needed to cover the full operand width.
  function automatic int calc_nstep(input int width, input int slice);
    return width / slice;
  endfunction

  // Width of the step counter; never below one bit so a single-step
  // configuration still has a legal vector.
  function automatic int calc_step_w(input int width, input int slice);
    int n;
    n = width / slice;
    if (n > 1) return $clog2(n);
    return 1;
  endfunction

endpackage

// File: rtl/rca_seq_adder64_if.sv
// Operand and result channels of the serial adder.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The source holds valid and its payload stable until that edge;
// the sink may raise or drop ready at any time. in_* carries operands into
// the adder, out_* carries the result out of it. dbg_state mirrors the
// controller state for observation only.
interface rca_seq_adder64_if import rca_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  state_e           dbg_state;

  // Requester side: supplies operands and consumes results.
  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, dbg_state
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, dbg_state
  );

endinterface

// File: rtl/rca_slice.sv
// Purely combinational W-bit ripple-carry adder slice: {co,s} = a + b + ci.
module rca_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o
);

  logic [W:0] total;

  // Zero-extend every term to W+1 bits so the carry lands in the top bit.
  assign total = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};
  assign s_o   = total[W-1:0];
  assign co_o  = total[W];

endmodule

// File: rtl/rca_seq_adder64.sv
// Multi-cycle WIDTH-bit adder built from one SLICE-bit ripple-carry slice.
// Operands are latched on accept, then one slice is added per clock, LSB
// slice first, with the carry chained through carry_q. The result is held
// on the output channel until the consumer takes it.
module rca_seq_adder64 import rca_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input logic              clk,
  input logic              rst,
  rca_seq_adder64_if.slave bus
);

  localparam int NSTEP  = calc_nstep(WIDTH, SLICE);
  localparam int STEP_W = calc_step_w(WIDTH, SLICE);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

  // A width that the slice does not divide would leave a ragged top slice.
  if (WIDTH % SLICE != 0) begin : g_bad_width
    $fatal(1, "rca_seq_adder64: WIDTH must be a multiple of SLICE");
  end

  state_e            state_q;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;
  logic [WIDTH-1:0]  op_a_q;
  logic [WIDTH-1:0]  op_b_q;
  logic              carry_q;
  logic [WIDTH-1:0]  sum_q;
  logic              c_out_q;
  logic              ovf_q;
  logic              ovf_d;
  logic              in_ready_q;
  logic              out_valid_q;

  logic [SLICE-1:0]  slice_a;
  logic [SLICE-1:0]  slice_b;
  logic [SLICE-1:0]  slice_s;
  logic              slice_co;

  // Select the operand slice addressed by the current step.
  assign slice_a = op_a_q[int'(step_q) * SLICE +: SLICE];
  assign slice_b = op_b_q[int'(step_q) * SLICE +: SLICE];

  rca_slice #(
    .W (SLICE)
  ) u_slice (
    .a_i  (slice_a),
    .b_i  (slice_b),
    .ci_i (carry_q),
    .s_o  (slice_s),
    .co_o (slice_co)
  );

  assign step_d = step_q + 1'b1;

  // Signed overflow: like-signed operands whose sum sign differs. The top
  // bit of the sum is produced by the last slice, so use it directly.
  assign ovf_d = (op_a_q[WIDTH-1] ~^ op_b_q[WIDTH-1]) &
                 (slice_s[SLICE-1] ^ op_a_q[WIDTH-1]);

  // Controller, step counter and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            op_a_q     <= bus.a;
            op_b_q     <= bus.b;
            carry_q    <= bus.c_in;
            step_q     <= '0;
            // Clear the previous result so no stale bits show mid-run.
            sum_q      <= '0;
            c_out_q    <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end

        RUN: begin
          sum_q[int'(step_q) * SLICE +: SLICE] <= slice_s;
          carry_q <= slice_co;
          step_q  <= step_d;
          if (step_q == LAST_STEP) begin
            c_out_q     <= slice_co;
            ovf_q       <= ovf_d;
            step_q      <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          // Result, carry and overflow hold until the consumer takes them.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_rca_seq_adder64.sv
// Bench for rca_seq_adder64: table vectors, back-pressure, mid-run reset
// and random traffic, all checked through an expected-result queue.
module tb_rca_seq_adder64;
  import rca_pkg::*;

  localparam int W = 64;

  logic clk = 1'b0;
  logic rst;

  // Clock and reset.
  always #5 clk = ~clk;

  rca_seq_adder64_if #(.WIDTH(W)) bus ();

  rca_seq_adder64 #(
    .WIDTH (W),
    .SLICE (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Expected results as {ovf, c_out, sum}.
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: exact 65-bit sum plus signed-overflow rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [W:0] full;
    logic       o;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    o    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {o, full};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  bus.in_ready,  1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_sum"},       bus.sum,       0);
    check({tag, "_c_out"},     bus.c_out,     0);
    check({tag, "_ovf"},       bus.ovf,       0);
    check({tag, "_state"},     bus.dbg_state, IDLE);
  endtask

  // Driver: present operands until accepted, push the expected result.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic [W+1:0] exp);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_timeout", n < 50, 1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = cin;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("accept_in_ready_low", bus.in_ready, 0);
  endtask

  // Wait for out_valid, counting cycles from the accept edge.
  task automatic wait_out(input bit poke_ready);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (poke_ready) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    bus.out_ready = 1'b0;
    check("latency", lat, 16);
  endtask

  // Consumer: stall, then take the result and compare it with the scoreboard.
  task automatic recv(input int stall, input bit toggle);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      e = '0;
    end else begin
      e = exp_q[0];
    end
    for (int i = 0; i < stall; i++) begin
      bus.out_ready = 1'b0;
      if (toggle) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.a        = {$urandom, $urandom};
        bus.b        = {$urandom, $urandom};
        bus.c_in     = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_result", {bus.ovf, bus.c_out, bus.sum}, e);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("out_valid_at_take", bus.out_valid, 1);
    check("result", {bus.ovf, bus.c_out, bus.sum}, e);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("after_take_out_valid", bus.out_valid, 0);
    check("after_take_in_ready", bus.in_ready, 1);
    check("after_take_state", bus.dbg_state, IDLE);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int           seen;

    vecs[0] = '{64'h1, 64'h2, 1'b0, 64'h3, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[4] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset_released");

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].ovf, vecs[i].cout, vecs[i].sum});
      wait_out(1'b0);
      recv(0, 1'b0);
    end

    // Back-pressure: 10 stalled cycles in DONE with noisy inputs.
    send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1,
         {1'b0, 1'b1, 64'h0000_0000_0000_0000});
    wait_out(1'b0);
    recv(10, 1'b1);

    // Asynchronous reset at step 7 discards the in-flight result.
    send(64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0,
         model(64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0));
    repeat (7) @(negedge clk);
    check("midrun_state", bus.dbg_state, RUN);
    rst = 1'b1;
    #1;
    check_reset_vals("midrun_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("no_pulse_after_reset", seen, 0);
    send(64'd5, 64'd6, 1'b0, {1'b0, 1'b0, 64'd11});
    wait_out(1'b0);
    recv(0, 1'b0);

    // Random traffic with consumer stalls.
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: rb = ~ra;
        1: ra = 64'hFFFF_FFFF_FFFF_FFFF;
        2: rb = 64'h7FFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      send(ra, rb, rc, model(ra, rb, rc));
      wait_out(1'b1);
      recv($urandom_range(0, 3), 1'b0);
    end

    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
